// File: rtl/alu_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | alu_sequencer: register file plus IDLE/EXEC/RESP sequencer for an ext. alu |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_sequencer #(
  parameter int N = 32,
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [2:0]   req_rs1,
  input  logic [2:0]   req_rs2,
  input  logic [2:0]   req_rd,
  input  logic         req_imm_sel,
  input  logic [N-1:0] req_imm,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         alu_overflow,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_overflow,
  output logic         rsp_zero,
  output logic         rsp_illegal,
  input  logic [2:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_OP_AND  = 4'b0001;
  localparam logic [3:0] c_OP_OR   = 4'b0010;
  localparam logic [3:0] c_OP_XOR  = 4'b0011;
  localparam logic [3:0] c_OP_SLL  = 4'b0101;
  localparam logic [3:0] c_OP_SRL  = 4'b0110;
  localparam logic [3:0] c_OP_SRA  = 4'b0111;
  localparam logic [3:0] c_OP_ADD  = 4'b1000;
  localparam logic [3:0] c_OP_SUB  = 4'b1100;
  localparam logic [3:0] c_OP_SLT  = 4'b1101;
  localparam logic [3:0] c_OP_SLTU = 4'b1111;

  state_t       r_state;
  logic         r_req_ready;
  logic [N-1:0] r_alu_a;
  logic [N-1:0] r_alu_b;
  logic [3:0]   r_alu_ctl;
  logic [2:0]   r_rd;
  logic         r_rsp_valid;
  logic [N-1:0] r_rsp_result;
  logic         r_rsp_overflow;
  logic         r_rsp_zero;
  logic         r_rsp_illegal;
  logic [N-1:0] r_regs [R];

  logic [N-1:0] w_rs1_val;
  logic [N-1:0] w_rs2_val;
  logic         w_legal;

  function automatic logic f_legal(input logic [3:0] op);
    case (op)
      c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_SLL, c_OP_SRL,
      c_OP_SRA, c_OP_ADD, c_OP_SUB, c_OP_SLT, c_OP_SLTU: f_legal = 1'b1;
      default:                                          f_legal = 1'b0;
    endcase
  endfunction

  assign w_rs1_val = (req_rs1 == 3'd0) ? '0 : r_regs[req_rs1];
  assign w_rs2_val = (req_rs2 == 3'd0) ? '0 : r_regs[req_rs2];
  assign w_legal   = f_legal(r_alu_ctl);

  // Operands are captured at accept time, so during EXEC the alu sees the
  // pre-write register values even when rd aliases rs1/rs2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_req_ready    <= 1'b0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_ctl      <= '0;
      r_rd           <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_illegal  <= 1'b0;
      for (int i = 0; i < R; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_req_ready) begin
            r_req_ready <= 1'b1;
          end else if (req_valid) begin
            r_alu_a     <= w_rs1_val;
            r_alu_b     <= req_imm_sel ? req_imm : w_rs2_val;
            r_alu_ctl   <= req_op;
            r_rd        <= req_rd;
            r_req_ready <= 1'b0;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_valid   <= 1'b1;
          r_rsp_illegal <= ~w_legal;
          if (w_legal) begin
            r_rsp_result   <= alu_result;
            r_rsp_overflow <= alu_overflow;
            r_rsp_zero     <= alu_zero;
            if (r_rd != 3'd0) begin
              r_regs[r_rd] <= alu_result;
            end
          end else begin
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
          end
          r_alu_a   <= '0;
          r_alu_b   <= '0;
          r_alu_ctl <= '0;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_control  = r_alu_ctl;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_illegal  = r_rsp_illegal;
  assign dbg_data     = (dbg_addr == 3'd0) ? '0 : r_regs[dbg_addr];

endmodule
`default_nettype wire
